mac_mgnt_slave: RTL and testbench

- Per-port management register endpoint on the byte-serial system management bus; one instance per MAC port and one per switch block, each driven by one bit of the hub's request-valid vector.
- Holds port configuration registers and 32-bit saturating statistics counters fed by MAC rx/tx event strobes.
- Serves 4-byte MSB-first reads and writes with a single-cycle acknowledge per transaction.

---
 rtl/mac_mgnt_slave.sv | 145 ++++++++++++++
 tb/tb_mac_mgnt_slave.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mac_mgnt_slave.sv
// mac_mgnt_slave: per-port management register endpoint with config and saturating statistics counters
module mac_mgnt_slave #(
  parameter int         MGNT_REG_WIDTH = 32,
  parameter logic [7:0] PORT_ID        = 8'h00,
  parameter int         RESP_DELAY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mgnt_req_valid,
  input  logic        mgnt_req_wr,
  input  logic [7:0]  mgnt_req_addr,
  input  logic [7:0]  mgnt_req_data,
  input  logic        mgnt_req_data_valid,
  output logic        mgnt_req_ack,
  output logic [7:0]  mgnt_resp_data,
  output logic        mgnt_resp_data_valid,
  input  logic        rx_frame_done,
  input  logic [15:0] rx_frame_len,
  input  logic        rx_crc_err,
  input  logic        tx_frame_done,
  input  logic [15:0] tx_frame_len,
  input  logic        link_up,
  input  logic [1:0]  link_speed,
  output logic        cfg_rx_en,
  output logic        cfg_tx_en
);
  localparam int NBYTES = MGNT_REG_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, WR_DATA, RD_WAIT, RD_DATA, ACK, HOLD} state_t;
  state_t            state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [7:0]        dly_q, dly_d;
  logic [2:0]        ctrl_q;
  logic [31:0]       scratch_q;
  logic [1:0]        cfg_q;
  logic              ack_q, ack_d;
  logic              resp_valid_q, resp_valid_d;
  logic [7:0]        resp_data_q, resp_data_d;
  logic [31:0]       rdata;
  logic [4:0]        ev;
  logic [4:0][31:0]  cnt;
  logic              rd_start, wr_commit;
  assign rd_start  = state_q == IDLE && mgnt_req_valid && !mgnt_req_wr;
  assign wr_commit = state_q == WR_DATA && mgnt_req_valid && bcnt_q == 3'(NBYTES);
  // counter order: rx frames, rx bytes, rx crc errors, tx frames, tx bytes
  assign ev = {tx_frame_done & cfg_q[1], tx_frame_done & cfg_q[1], rx_crc_err,
               rx_frame_done & cfg_q[0], rx_frame_done & cfg_q[0]};
  assign mgnt_req_ack         = ack_q;
  assign mgnt_resp_data       = resp_data_q;
  assign mgnt_resp_data_valid = resp_valid_q;
  assign cfg_rx_en            = cfg_q[0];
  assign cfg_tx_en            = cfg_q[1];
  // register map read mux, sampled into the shift register when a read is accepted
  always_comb begin
    case (mgnt_req_addr)
      8'h00:   rdata = {29'b0, ctrl_q};
      8'h01:   rdata = {16'b0, PORT_ID, 5'b0, link_speed, link_up};
      8'h10:   rdata = cnt[0];
      8'h11:   rdata = cnt[1];
      8'h12:   rdata = cnt[2];
      8'h13:   rdata = cnt[3];
      8'h14:   rdata = cnt[4];
      8'h20:   rdata = scratch_q;
      default: rdata = '0;
    endcase
  end
  for (genvar i = 0; i < 5; i++) begin : g_cnt
    logic [31:0] add, cnt_q;
    logic [32:0] sum;
    logic        clr;
    assign add = !ev[i] ? 32'd0 : i == 1 ? {16'b0, rx_frame_len} : i == 4 ? {16'b0, tx_frame_len} : 32'd1;
    assign sum = {1'b0, cnt_q} + {1'b0, add};
    assign clr = rd_start && ctrl_q[2] && mgnt_req_addr == 8'h10 + 8'(i);
    assign cnt[i] = cnt_q;
    // saturating counter; a clear-on-read keeps any same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= clr ? add : sum[32] ? '1 : sum[31:0];
    end
  end
  // transaction sequencing: byte collection, read delay, byte streaming, ack and release
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    dly_d   = dly_q;
    case (state_q)
      IDLE: if (mgnt_req_valid) begin
        state_d = mgnt_req_wr ? WR_DATA : RD_WAIT;
        shift_d = rdata;
        bcnt_d  = '0;
        dly_d   = 8'(RESP_DELAY - 1);
      end
      WR_DATA: if (!mgnt_req_valid) state_d = IDLE;
        else if (bcnt_q == 3'(NBYTES)) state_d = ACK;
        else if (mgnt_req_data_valid) begin
          shift_d = {shift_q[23:0], mgnt_req_data};
          bcnt_d  = bcnt_q + 3'd1;
        end
      RD_WAIT: if (!mgnt_req_valid) state_d = IDLE;
        else if (dly_q == 8'd0) begin
          state_d = RD_DATA;
          bcnt_d  = '0;
        end else dly_d = dly_q - 8'd1;
      RD_DATA: if (!mgnt_req_valid) state_d = IDLE;
        else begin
          shift_d = {shift_q[23:0], 8'h00};
          bcnt_d  = bcnt_q + 3'd1;
          state_d = bcnt_q == 3'(NBYTES - 1) ? ACK : RD_DATA;
        end
      ACK:     state_d = HOLD;
      HOLD:    state_d = mgnt_req_valid ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
    ack_d        = state_q == ACK;
    resp_valid_d = state_q == RD_DATA && mgnt_req_valid;
    resp_data_d  = resp_valid_d ? shift_q[31:24] : 8'h00;
  end
  // state, registered bus outputs, and the writable registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bcnt_q       <= '0;
      dly_q        <= '0;
      ctrl_q       <= 3'b011;
      scratch_q    <= '0;
      cfg_q        <= 2'b11;
      ack_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcnt_q       <= bcnt_d;
      dly_q        <= dly_d;
      ctrl_q       <= wr_commit && mgnt_req_addr == 8'h00 ? shift_q[2:0] : ctrl_q;
      scratch_q    <= wr_commit && mgnt_req_addr == 8'h20 ? shift_q : scratch_q;
      cfg_q        <= ctrl_q[1:0];
      ack_q        <= ack_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_mac_mgnt_slave.sv
// tb_mac_mgnt_slave: directed bench for the management register endpoint
module tb_mac_mgnt_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mgnt_req_valid = 1'b0, mgnt_req_wr = 1'b0, mgnt_req_data_valid = 1'b0;
  logic [7:0]  mgnt_req_addr = '0, mgnt_req_data = '0;
  logic        mgnt_req_ack, mgnt_resp_data_valid, cfg_rx_en, cfg_tx_en;
  logic [7:0]  mgnt_resp_data;
  logic        rx_frame_done = 1'b0, rx_crc_err = 1'b0, tx_frame_done = 1'b0;
  logic [15:0] rx_frame_len = '0, tx_frame_len = '0;
  logic        link_up = 1'b1;
  logic [1:0]  link_speed = 2'b10;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] d;
  int          f, a, acks;
  mac_mgnt_slave #(.MGNT_REG_WIDTH(32), .PORT_ID(8'hA5), .RESP_DELAY(2)) dut (
    .clk(clk), .rst(rst),
    .mgnt_req_valid(mgnt_req_valid), .mgnt_req_wr(mgnt_req_wr), .mgnt_req_addr(mgnt_req_addr),
    .mgnt_req_data(mgnt_req_data), .mgnt_req_data_valid(mgnt_req_data_valid),
    .mgnt_req_ack(mgnt_req_ack), .mgnt_resp_data(mgnt_resp_data), .mgnt_resp_data_valid(mgnt_resp_data_valid),
    .rx_frame_done(rx_frame_done), .rx_frame_len(rx_frame_len), .rx_crc_err(rx_crc_err),
    .tx_frame_done(tx_frame_done), .tx_frame_len(tx_frame_len),
    .link_up(link_up), .link_speed(link_speed),
    .cfg_rx_en(cfg_rx_en), .cfg_tx_en(cfg_tx_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [7:0] adr, input logic ev, output logic [31:0] dat, output int first, output int ackc);
    int nb = 0;
    dat = '0; first = 0; ackc = 0;
    @(posedge clk); #1;
    mgnt_req_valid = 1'b1; mgnt_req_wr = 1'b0; mgnt_req_addr = adr;
    if (ev) begin rx_frame_done = 1'b1; rx_frame_len = 16'd100; end
    for (int i = 1; i <= 30 && ackc == 0; i++) begin
      @(negedge clk);
      if (i == 2) rx_frame_done = 1'b0;
      if (mgnt_resp_data_valid) begin
        if (nb == 0) first = i;
        dat = {dat[23:0], mgnt_resp_data};
        nb++;
      end
      if (mgnt_req_ack) ackc = i;
    end
    @(posedge clk); #1; mgnt_req_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [7:0] adr, input logic [31:0] v, output int ackc);
    @(posedge clk); #1;
    mgnt_req_valid = 1'b1; mgnt_req_wr = 1'b1; mgnt_req_addr = adr;
    for (int b = 3; b >= 0; b--) begin
      @(posedge clk); #1; mgnt_req_data = v[b*8 +: 8]; mgnt_req_data_valid = 1'b1;
    end
    @(posedge clk); #1; mgnt_req_data_valid = 1'b0;
    ackc = 0;
    for (int i = 1; i <= 10 && ackc == 0; i++) begin
      @(negedge clk);
      if (mgnt_req_ack) ackc = i;
    end
    @(posedge clk); #1; mgnt_req_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic pulse(input int k, input logic [15:0] len, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_frame_done = k == 0; rx_crc_err = k == 1; tx_frame_done = k == 2;
      rx_frame_len = len; tx_frame_len = len;
    end
    @(posedge clk); #1;
    rx_frame_done = 1'b0; rx_crc_err = 1'b0; tx_frame_done = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", mgnt_req_ack, 0);
    chk("rst_resp_valid", mgnt_resp_data_valid, 0);
    chk("rst_resp_data", mgnt_resp_data, 0);
    chk("rst_cfg", {cfg_tx_en, cfg_rx_en}, 2'b11);
    @(posedge clk); #1; rst = 1'b0;
    rd(8'h00, 1'b0, d, f, a);
    chk("ctrl_rst", d, 32'h3);
    chk("rd_first_byte_cycle", f, 5);
    chk("rd_ack_cycle", a, 9);
    rd(8'h01, 1'b0, d, f, a);
    chk("status", d, 32'h0000A505);
    wr(8'h20, 32'hDEADBEEF, a);
    chk("wr_scratch_ack", a != 0, 1);
    rd(8'h20, 1'b0, d, f, a);
    chk("scratch", d, 32'hDEADBEEF);
    wr(8'h00, 32'h0, a);
    chk("cfg_off", {cfg_tx_en, cfg_rx_en}, 2'b00);
    pulse(0, 16'd64, 3);
    pulse(1, 16'd0, 2);
    rd(8'h10, 1'b0, d, f, a);
    chk("rx_frames_gated", d, 0);
    rd(8'h11, 1'b0, d, f, a);
    chk("rx_bytes_gated", d, 0);
    wr(8'h00, 32'h1, a);
    chk("cfg_rx_only", {cfg_tx_en, cfg_rx_en}, 2'b01);
    pulse(0, 16'd1500, 2);
    rd(8'h10, 1'b0, d, f, a);
    chk("rx_frames", d, 2);
    rd(8'h11, 1'b0, d, f, a);
    chk("rx_bytes", d, 3000);
    rd(8'h12, 1'b0, d, f, a);
    chk("rx_crc_err", d, 2);
    wr(8'h00, 32'h7, a);
    pulse(0, 16'd10, 3);
    rd(8'h10, 1'b1, d, f, a);
    chk("cor_frames_snapshot", d, 5);
    rd(8'h10, 1'b0, d, f, a);
    chk("cor_frames_kept_event", d, 1);
    rd(8'h11, 1'b0, d, f, a);
    chk("cor_bytes", d, 3130);
    rd(8'h11, 1'b0, d, f, a);
    chk("cor_bytes_cleared", d, 0);
    wr(8'h00, 32'h3, a);
    rd(8'h55, 1'b0, d, f, a);
    chk("unmapped_rd", d, 0);
    chk("unmapped_rd_ack", a != 0, 1);
    wr(8'h55, 32'h12345678, a);
    chk("unmapped_wr_ack", a != 0, 1);
    @(posedge clk); #1;
    mgnt_req_valid = 1'b1; mgnt_req_wr = 1'b1; mgnt_req_addr = 8'h20;
    @(posedge clk); #1; mgnt_req_data = 8'h11; mgnt_req_data_valid = 1'b1;
    @(posedge clk); #1; mgnt_req_data = 8'h22;
    @(posedge clk); #1; mgnt_req_data_valid = 1'b0; mgnt_req_valid = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (mgnt_req_ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    rd(8'h20, 1'b0, d, f, a);
    chk("abort_scratch_kept", d, 32'hDEADBEEF);
    chk("abort_next_ack", a, 9);
    @(posedge clk); #1; tx_frame_done = 1'b1; tx_frame_len = 16'hFFFF;
    repeat (65536) @(posedge clk);
    #1; tx_frame_len = 16'h0200;
    @(posedge clk); #1; tx_frame_done = 1'b0;
    rd(8'h14, 1'b0, d, f, a);
    chk("tx_bytes_near_max", d, 32'hFFFF0200);
    pulse(2, 16'hFFFF, 1);
    rd(8'h14, 1'b0, d, f, a);
    chk("tx_bytes_sat", d, 32'hFFFFFFFF);
    pulse(2, 16'd5, 1);
    rd(8'h14, 1'b0, d, f, a);
    chk("tx_bytes_stay_sat", d, 32'hFFFFFFFF);
    rd(8'h13, 1'b0, d, f, a);
    chk("tx_frames", d, 32'h00010003);
    @(posedge clk); #1;
    mgnt_req_valid = 1'b1; mgnt_req_wr = 1'b0; mgnt_req_addr = 8'h20;
    repeat (5) @(negedge clk);
    chk("pre_rst_streaming", mgnt_resp_data_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", mgnt_resp_data_valid, 0);
    chk("rst_mid_ack", mgnt_req_ack, 0);
    @(posedge clk); #1; mgnt_req_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_cfg", {cfg_tx_en, cfg_rx_en}, 2'b11);
    rd(8'h20, 1'b0, d, f, a);
    chk("rst_mid_scratch", d, 0);
    rd(8'h13, 1'b0, d, f, a);
    chk("rst_mid_counter", d, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
